// File: rtl/lsq_mem_arbiter_pkg.sv
// Shared definitions for the LSQ/memory arbiter: bus commands, load-queue
// index width and the layout of one outstanding-load tag entry.
package sys_defs;

  localparam int LQ_IDX_W = 3;
  localparam int TAG_W    = 4;
  localparam int NUM_TAGS = 15;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  typedef struct packed {
    logic                busy;
    logic                squashed;
    logic [LQ_IDX_W-1:0] idx;
    logic                thread1;
  } ld_tag_entry_t;

endpackage

// File: rtl/mem_tag_table.sv
// Outstanding-load tag table: allocates on accepted loads, squashes per thread,
// frees on data return and emits a registered one-cycle completion pulse.
module mem_tag_table
  import sys_defs::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                alloc_en_i,
  input  logic [TAG_W-1:0]    alloc_tag_i,
  input  logic [LQ_IDX_W-1:0] alloc_idx_i,
  input  logic                alloc_thread1_i,
  input  logic                squash_t1_i,
  input  logic                squash_t2_i,
  input  logic [TAG_W-1:0]    ret_tag_i,
  input  logic [63:0]         ret_data_i,
  output logic                done_valid_o,
  output logic [LQ_IDX_W-1:0] done_idx_o,
  output logic                done_thread1_o,
  output logic [63:0]         done_data_o,
  output logic                tags_full_o
);

  ld_tag_entry_t       tab_q [1:NUM_TAGS];
  ld_tag_entry_t       tab_d [1:NUM_TAGS];
  logic                done_valid_q, done_valid_d;
  logic [LQ_IDX_W-1:0] done_idx_q, done_idx_d;
  logic                done_thread1_q, done_thread1_d;
  logic [63:0]         done_data_q, done_data_d;
  logic                tags_full_q;
  logic [TAG_W:0]      busy_cnt;
  logic                squash_now;

  always_comb begin
    done_valid_d   = 1'b0;
    done_idx_d     = '0;
    done_thread1_d = 1'b0;
    done_data_d    = '0;
    busy_cnt       = '0;
    squash_now     = 1'b0;
    for (int i = 1; i <= NUM_TAGS; i++) begin
      tab_d[i]   = tab_q[i];
      squash_now = tab_q[i].busy &&
                   ((squash_t1_i && tab_q[i].thread1) || (squash_t2_i && !tab_q[i].thread1));
      if (squash_now) tab_d[i].squashed = 1'b1;
      // A squash arriving in the same cycle as the return still drops the data.
      if (tab_q[i].busy && ret_tag_i == TAG_W'(i)) begin
        tab_d[i].busy     = 1'b0;
        tab_d[i].squashed = 1'b0;
        if (!tab_q[i].squashed && !squash_now) begin
          done_valid_d   = 1'b1;
          done_idx_d     = tab_q[i].idx;
          done_thread1_d = tab_q[i].thread1;
          done_data_d    = ret_data_i;
        end
      end
      if (alloc_en_i && alloc_tag_i == TAG_W'(i)) begin
        tab_d[i] = '{busy: 1'b1, squashed: 1'b0, idx: alloc_idx_i, thread1: alloc_thread1_i};
      end
    end
    for (int i = 1; i <= NUM_TAGS; i++) begin
      busy_cnt = busy_cnt + (TAG_W+1)'(tab_d[i].busy);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 1; i <= NUM_TAGS; i++) tab_q[i] <= '0;
      done_valid_q   <= 1'b0;
      done_idx_q     <= '0;
      done_thread1_q <= 1'b0;
      done_data_q    <= '0;
      tags_full_q    <= 1'b0;
    end else begin
      for (int i = 1; i <= NUM_TAGS; i++) tab_q[i] <= tab_d[i];
      done_valid_q   <= done_valid_d;
      done_idx_q     <= done_idx_d;
      done_thread1_q <= done_thread1_d;
      done_data_q    <= done_data_d;
      tags_full_q    <= (busy_cnt == (TAG_W+1)'(NUM_TAGS));
    end
  end

  assign done_valid_o   = done_valid_q;
  assign done_idx_o     = done_idx_q;
  assign done_thread1_o = done_thread1_q;
  assign done_data_o    = done_data_q;
  assign tags_full_o    = tags_full_q;

endmodule

// File: rtl/lsq_mem_arbiter.sv
// Shares the single data-memory port between two per-thread store queues and
// the load queue, with store round-robin and a starvation override for stores.
module lsq_mem_arbiter
  import sys_defs::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sq_t1_valid,
  input  logic [63:0]         sq_t1_addr,
  input  logic [63:0]         sq_t1_data,
  output logic                sq_t1_grant,
  input  logic                sq_t2_valid,
  input  logic [63:0]         sq_t2_addr,
  input  logic [63:0]         sq_t2_data,
  output logic                sq_t2_grant,
  input  logic                lq_valid,
  input  logic [63:0]         lq_addr,
  input  logic [LQ_IDX_W-1:0] lq_idx,
  input  logic                lq_thread1,
  output logic                lq_grant,
  input  logic                thread1_mispredict,
  input  logic                thread2_mispredict,
  output bus_cmd_e            proc2mem_command,
  output logic [63:0]         proc2mem_addr,
  output logic [63:0]         proc2mem_data,
  input  logic [TAG_W-1:0]    mem2proc_response,
  input  logic [TAG_W-1:0]    mem2proc_tag,
  input  logic [63:0]         mem2proc_data,
  output logic                ld_done_valid,
  output logic [LQ_IDX_W-1:0] ld_done_idx,
  output logic                ld_done_thread1,
  output logic [63:0]         ld_done_data,
  output logic                tags_full
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             last_st_t1_q, last_st_t1_d;
  logic             any_st, pick_t1, ld_ok, forced, accept, st_granted, ld_alloc;
  bus_cmd_e         sel;

  assign any_st  = sq_t1_valid | sq_t2_valid;
  assign pick_t1 = sq_t1_valid & (~sq_t2_valid | ~last_st_t1_q);
  assign ld_ok   = lq_valid & ~tags_full &
                   ~(lq_thread1 ? thread1_mispredict : thread2_mispredict);
  assign forced  = any_st && (starve_cnt_q == CNT_W'(STARVE_LIMIT));
  assign accept  = (mem2proc_response != '0);

  // Handshake: each requester holds valid and payload steady until its grant;
  // grant = selected && memory accepted (response != 0), same cycle.
  always_comb begin
    sel              = BUS_NONE;
    sq_t1_grant      = 1'b0;
    sq_t2_grant      = 1'b0;
    lq_grant         = 1'b0;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (!reset)      sel = BUS_NONE;
    else if (forced) sel = BUS_STORE;
    else if (ld_ok)  sel = BUS_LOAD;
    else if (any_st) sel = BUS_STORE;
    case (sel)
      BUS_LOAD: begin
        proc2mem_addr = lq_addr;
        lq_grant      = accept;
      end
      BUS_STORE: begin
        proc2mem_addr = pick_t1 ? sq_t1_addr : sq_t2_addr;
        proc2mem_data = pick_t1 ? sq_t1_data : sq_t2_data;
        sq_t1_grant   = accept & pick_t1;
        sq_t2_grant   = accept & ~pick_t1;
      end
      default: ;
    endcase
    proc2mem_command = sel;
  end

  assign st_granted = sq_t1_grant | sq_t2_grant;
  assign ld_alloc   = lq_grant;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!any_st || st_granted)                    starve_cnt_d = '0;
    else if (starve_cnt_q != CNT_W'(STARVE_LIMIT)) starve_cnt_d = starve_cnt_q + 1'b1;
    last_st_t1_d = st_granted ? pick_t1 : last_st_t1_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      starve_cnt_q <= '0;
      last_st_t1_q <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      last_st_t1_q <= last_st_t1_d;
    end
  end

  mem_tag_table u_tag_table (
    .clock           (clock),
    .reset           (reset),
    .alloc_en_i      (ld_alloc),
    .alloc_tag_i     (mem2proc_response),
    .alloc_idx_i     (lq_idx),
    .alloc_thread1_i (lq_thread1),
    .squash_t1_i     (thread1_mispredict),
    .squash_t2_i     (thread2_mispredict),
    .ret_tag_i       (mem2proc_tag),
    .ret_data_i      (mem2proc_data),
    .done_valid_o    (ld_done_valid),
    .done_idx_o      (ld_done_idx),
    .done_thread1_o  (ld_done_thread1),
    .done_data_o     (ld_done_data),
    .tags_full_o     (tags_full)
  );

endmodule

// File: tb/tb_lsq_mem_arbiter.sv
// Directed bench for lsq_mem_arbiter: store round-robin, load issue/return,
// starvation override, squash, tag exhaustion and mid-run reset.
module tb_lsq_mem_arbiter;
  import sys_defs::*;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic                sq_t1_valid, sq_t2_valid, sq_t1_grant, sq_t2_grant;
  logic [63:0]         sq_t1_addr, sq_t1_data, sq_t2_addr, sq_t2_data;
  logic                lq_valid, lq_thread1, lq_grant;
  logic [63:0]         lq_addr;
  logic [LQ_IDX_W-1:0] lq_idx;
  logic                thread1_mispredict, thread2_mispredict;
  bus_cmd_e            proc2mem_command;
  logic [63:0]         proc2mem_addr, proc2mem_data;
  logic [TAG_W-1:0]    mem2proc_response, mem2proc_tag;
  logic [63:0]         mem2proc_data;
  logic                ld_done_valid, ld_done_thread1, tags_full;
  logic [LQ_IDX_W-1:0] ld_done_idx;
  logic [63:0]         ld_done_data;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_q[$];

  lsq_mem_arbiter #(.STARVE_LIMIT(8)) dut (
    .clock(clock), .reset(reset),
    .sq_t1_valid(sq_t1_valid), .sq_t1_addr(sq_t1_addr), .sq_t1_data(sq_t1_data), .sq_t1_grant(sq_t1_grant),
    .sq_t2_valid(sq_t2_valid), .sq_t2_addr(sq_t2_addr), .sq_t2_data(sq_t2_data), .sq_t2_grant(sq_t2_grant),
    .lq_valid(lq_valid), .lq_addr(lq_addr), .lq_idx(lq_idx), .lq_thread1(lq_thread1), .lq_grant(lq_grant),
    .thread1_mispredict(thread1_mispredict), .thread2_mispredict(thread2_mispredict),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_tag(mem2proc_tag), .mem2proc_data(mem2proc_data),
    .ld_done_valid(ld_done_valid), .ld_done_idx(ld_done_idx), .ld_done_thread1(ld_done_thread1),
    .ld_done_data(ld_done_data), .tags_full(tags_full)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic idle();
    sq_t1_valid = 0; sq_t1_addr = '0; sq_t1_data = '0;
    sq_t2_valid = 0; sq_t2_addr = '0; sq_t2_data = '0;
    lq_valid = 0; lq_addr = '0; lq_idx = '0; lq_thread1 = 0;
    thread1_mispredict = 0; thread2_mispredict = 0;
    mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_load(input logic [63:0] addr, input int idx, input logic t1, input int resp);
    lq_valid = 1; lq_addr = addr; lq_idx = LQ_IDX_W'(idx); lq_thread1 = t1;
    mem2proc_response = TAG_W'(resp);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_t1g"}, sq_t1_grant, 0);
    check_eq({tag, "_t2g"}, sq_t2_grant, 0);
    check_eq({tag, "_lqg"}, lq_grant, 0);
    check_eq({tag, "_cmd"}, proc2mem_command, BUS_NONE);
    check_eq({tag, "_addr"}, proc2mem_addr, 0);
    check_eq({tag, "_data"}, proc2mem_data, 0);
    check_eq({tag, "_done"}, ld_done_valid, 0);
    check_eq({tag, "_full"}, tags_full, 0);
  endtask

  initial begin
    idle();
    reset = 0;
    step(); step();
    #1 check_quiet("rst");
    reset = 1;

    // store round-robin: t1, t2, t1
    sq_t1_valid = 1; sq_t1_addr = 64'h100; sq_t1_data = 64'h111;
    sq_t2_valid = 1; sq_t2_addr = 64'h200; sq_t2_data = 64'h222;
    mem2proc_response = 4'd3;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("rr_t1g", sq_t1_grant, (k != 1));
      check_eq("rr_t2g", sq_t2_grant, (k == 1));
      check_eq("rr_cmd", proc2mem_command, BUS_STORE);
      check_eq("rr_addr", proc2mem_addr, (k == 1) ? 64'h200 : 64'h100);
      check_eq("rr_data", proc2mem_data, (k == 1) ? 64'h222 : 64'h111);
      step();
    end
    idle();

    // load beats an ordinary store; return two cycles later
    sq_t1_valid = 1; sq_t1_addr = 64'h500; sq_t1_data = 64'h555;
    drive_load(64'hF0, 5, 1, 4);
    #1;
    check_eq("ld_grant", lq_grant, 1);
    check_eq("ld_st_lose", sq_t1_grant, 0);
    check_eq("ld_cmd", proc2mem_command, BUS_LOAD);
    check_eq("ld_addr", proc2mem_addr, 64'hF0);
    check_eq("ld_data0", proc2mem_data, 0);
    step(); idle(); step();
    mem2proc_tag = 4'd4; mem2proc_data = 64'hABCD;
    exp_q.push_back(64'hABCD);
    #1 check_eq("ld_done_early", ld_done_valid, 0);
    step();
    mem2proc_tag = '0; mem2proc_data = '0;
    check_eq("ld_done_v", ld_done_valid, 1);
    check_eq("ld_done_idx", ld_done_idx, 5);
    check_eq("ld_done_t1", ld_done_thread1, 1);
    check_eq("ld_done_data", ld_done_data, exp_q.pop_front());
    step();
    check_eq("ld_done_pulse", ld_done_valid, 0);

    // starvation: store loses 8 times, forced on the 9th
    idle();
    sq_t1_valid = 1; sq_t1_addr = 64'h300; sq_t1_data = 64'h333;
    for (int i = 1; i <= 8; i++) begin
      drive_load(64'h40, i, 1, i);
      #1;
      check_eq("stv_lqg", lq_grant, 1);
      check_eq("stv_t1g", sq_t1_grant, 0);
      step();
    end
    drive_load(64'h40, 1, 1, 9);
    #1;
    check_eq("stv_force_t1g", sq_t1_grant, 1);
    check_eq("stv_force_lqg", lq_grant, 0);
    check_eq("stv_force_cmd", proc2mem_command, BUS_STORE);
    check_eq("stv_force_addr", proc2mem_addr, 64'h300);
    step(); idle();
    thread1_mispredict = 1;
    step(); idle();
    for (int i = 1; i <= 8; i++) begin
      mem2proc_tag = TAG_W'(i); mem2proc_data = 64'(i);
      step();
      check_eq("stv_squash_ret", ld_done_valid, 0);
    end
    idle();

    // thread-2 load squashed before return, then tag 7 reused
    drive_load(64'h80, 2, 0, 7);
    #1 check_eq("sq2_grant", lq_grant, 1);
    step(); idle();
    thread2_mispredict = 1;
    drive_load(64'h88, 1, 0, 6);
    #1;
    check_eq("sq2_blocked", lq_grant, 0);
    check_eq("sq2_blk_cmd", proc2mem_command, BUS_NONE);
    step(); idle();
    mem2proc_tag = 4'd7; mem2proc_data = 64'h77;
    step(); idle();
    check_eq("sq2_dropped", ld_done_valid, 0);
    drive_load(64'h90, 3, 0, 7);
    #1 check_eq("reuse_grant", lq_grant, 1);
    step(); idle();
    mem2proc_tag = 4'd7; mem2proc_data = 64'h1234;
    exp_q.push_back(64'h1234);
    step(); idle();
    check_eq("reuse_done_v", ld_done_valid, 1);
    check_eq("reuse_done_idx", ld_done_idx, 3);
    check_eq("reuse_done_t1", ld_done_thread1, 0);
    check_eq("reuse_done_data", ld_done_data, exp_q.pop_front());

    // mispredict in the same cycle as the return drops the data
    drive_load(64'hB0, 4, 1, 5);
    #1 check_eq("same_grant", lq_grant, 1);
    step(); idle();
    mem2proc_tag = 4'd5; mem2proc_data = 64'h55; thread1_mispredict = 1;
    step(); idle();
    check_eq("same_dropped", ld_done_valid, 0);

    // exhaust all 15 tags
    for (int i = 1; i <= 15; i++) begin
      drive_load(64'hA0, i, 1, i);
      #1 check_eq("fill_grant", lq_grant, 1);
      step();
    end
    check_eq("full_set", tags_full, 1);
    sq_t2_valid = 1; sq_t2_addr = 64'h600; sq_t2_data = 64'h666;
    mem2proc_response = 4'd2;
    #1;
    check_eq("full_lqg", lq_grant, 0);
    check_eq("full_t2g", sq_t2_grant, 1);
    check_eq("full_cmd", proc2mem_command, BUS_STORE);
    check_eq("full_addr", proc2mem_addr, 64'h600);
    step(); idle();
    mem2proc_tag = 4'd3; mem2proc_data = 64'h33;
    step(); idle();
    check_eq("full_clear", tags_full, 0);
    check_eq("full_ret_idx", ld_done_idx, 3);

    // reset with loads outstanding
    reset = 0;
    step();
    reset = 1;
    for (int i = 1; i <= 3; i++) begin
      drive_load(64'hC0, i, 0, i);
      #1 check_eq("pre_rst_grant", lq_grant, 1);
      step();
    end
    idle();
    reset = 0;
    drive_load(64'hD0, 6, 1, 5);
    mem2proc_tag = 4'd1; mem2proc_data = 64'h99;
    #1;
    check_eq("in_rst_lqg", lq_grant, 0);
    check_eq("in_rst_cmd", proc2mem_command, BUS_NONE);
    step();
    reset = 1;
    idle();
    #1 check_quiet("post_rst");
    for (int i = 1; i <= 3; i++) begin
      mem2proc_tag = TAG_W'(i); mem2proc_data = 64'(i + 16);
      step();
      check_eq("stale_ret", ld_done_valid, 0);
    end
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsq_mem_arbiter.md
# lsq_mem_arbiter

Arbiter that shares the single data-memory port between the two per-thread store queues (committed stores draining to memory) and the load queue. It sequences requests onto `proc2mem_*` and tracks outstanding load tags. It routes returning load data back to the load queue and drops data for loads squashed by a thread mispredict. It sits between `sq`/load queue and the memory bus in the 2-way SMT core.

## Interface
- `STARVE_LIMIT`, 8: cycles a pending store may lose to loads before it is forced.
- `LQ_IDX_W`, 3: width of load-queue index.
- `clock` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-low; state clears on a rising edge with `reset==0`.
- `sq_t1_valid` / `sq_t2_valid` in 1: thread-1 / thread-2 store queue head holds a committed store.
- `sq_t1_addr`, `sq_t1_data`, `sq_t2_addr`, `sq_t2_data` in 64: store address and data.
- `sq_t1_grant` / `sq_t2_grant` out 1: store accepted by memory this cycle; SQ pops its head.
- `lq_valid` in 1: load request. `lq_addr` in 64. `lq_idx` in `LQ_IDX_W`. `lq_thread1` in 1 (1 = thread 1).
- `lq_grant` out 1: load accepted this cycle.
- `thread1_mispredict`, `thread2_mispredict` in 1: squash that thread's in-flight loads.
- `proc2mem_command` out 2: `BUS_NONE` / `BUS_LOAD` / `BUS_STORE`. `proc2mem_addr`, `proc2mem_data` out 64.
- `mem2proc_response` in 4: tag assigned to this cycle's command; 0 = rejected.
- `mem2proc_tag` in 4: tag of returning load data, 0 = none. `mem2proc_data` in 64.
- `ld_done_valid` out 1, `ld_done_idx` out `LQ_IDX_W`, `ld_done_thread1` out 1, `ld_done_data` out 64: load completion to the LQ.
- `tags_full` out 1: all 15 load tags are outstanding.

## Operation
- Selection is combinational each cycle, evaluated in this priority order:
  - Forced store: `starve_cnt==STARVE_LIMIT` and a store is valid.
  - Load: `lq_valid`, `!tags_full`, and the load's thread is not mispredicting this cycle.
  - Store: any store valid.
  - Otherwise `BUS_NONE`.
- Store thread pick:
  - Only one thread valid: that thread.
  - Both valid: the thread opposite `last_st_t1`.
  - `last_st_t1` updates only on an accepted store.
- A command is accepted iff `mem2proc_response != 0`. The grant for the selected requester equals acceptance. Requesters hold valid and payload until granted.
- `proc2mem_data` carries the store data for stores and is 0 otherwise. `proc2mem_addr` is 0 when the command is `BUS_NONE`.
- Starvation counter:
  - Increments (saturating at `STARVE_LIMIT`) on each cycle a store is valid and no store is granted.
  - Clears on a store grant, or when no store is valid.
- Load tag table: 15 entries indexed by tag 1..15, each holding {busy, squashed, idx, thread1}.
  - An accepted load writes entry `mem2proc_response` with busy=1, squashed=0.
- Mispredict: sets `squashed` on every busy entry of the matching thread. Both mispredict inputs may be asserted together.
- Load return: when `mem2proc_tag` hits a busy entry, the entry frees.
  - If not squashed, the `ld_done_*` outputs assert next cycle.
  - If squashed, the data is dropped.
  - A hit on a non-busy entry is ignored.
- Same cycle free and allocate of one tag: the allocate wins, so the entry is busy with new contents.
- A mispredict in the same cycle as a return of that thread's tag: the data is dropped.
- `tags_full` is registered from the busy count, which is 0..15.

## Timing
- Request-to-grant: 0 cycles (combinational).
- Tag return to `ld_done_valid`: 1 cycle (registered). `ld_done_valid` is a single-cycle pulse.
- Reset values:
  - All grants 0, `proc2mem_command` = `BUS_NONE`, addr/data 0.
  - `ld_done_*` 0, `tags_full` 0.
  - Table cleared, `starve_cnt` 0, `last_st_t1` 0 (thread 1 wins the first tie).
- Reset mid-operation: all tags are forgotten, and later returns of pre-reset tags are ignored.
- Rejected command (response 0): no grant, table unchanged; only `starve_cnt` may advance.

## Structure
- Shared `sys_defs` package:
  - `BUS_NONE`, `BUS_LOAD`, `BUS_STORE`.
  - `LQ_IDX_W`.
  - Load-tag entry struct typedef.
- Sub-module `mem_tag_table`: 15-entry alloc/free/squash table with registered completion outputs.
- Selection logic, round-robin pointer and starvation counter stay in the top module.

## Test plan
- Both stores valid, load idle, response 3 every cycle:
  - Grants alternate t1, t2, t1.
  - `proc2mem_command`=`BUS_STORE` with the matching addr/data.
- Load (addr 0xF0, idx 5, thread1) together with a t1 store, response 4:
  - `lq_grant`=1, `BUS_LOAD` @0xF0.
  - `mem2proc_tag`=4 with data 0xABCD two cycles later, then `ld_done_valid`=1, idx 5, data 0xABCD one cycle after that.
- Store held valid with loads issuing every cycle:
  - Store loses for 8 cycles, then on the 9th cycle `sq_t1_grant`=1 and `lq_grant`=0.
- Thread-2 load issued with tag 7, then `thread2_mispredict`=1 before return:
  - Return of tag 7 produces no `ld_done_valid`.
  - Tag 7 is reusable afterwards.
- 15 accepted loads with no returns:
  - `tags_full`=1 and further loads are not granted while stores still drain.
  - One return clears `tags_full` the next cycle.
- `reset`=0 while 3 loads are outstanding:
  - All outputs are 0 next cycle.
  - Later returns of those tags produce no `ld_done_valid`.
